// File: rtl/ysyx_trap_ctrl_pkg.sv
// ============================================================================
// Module   : ysyx_trap_ctrl_pkg
// Purpose  : Shared types, privilege levels and cause codes for the trap sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

package ysyx_trap_ctrl_pkg;

  localparam int XLEN = `YSYX_XLEN;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  localparam logic [3:0] ECALL_U    = 4'd8;
  localparam logic [3:0] ECALL_S    = 4'd9;
  localparam logic [3:0] ECALL_M    = 4'd11;
  localparam logic [3:0] BREAKPOINT = 4'd3;
  localparam logic [3:0] IRQ_MSI    = 4'd3;
  localparam logic [3:0] IRQ_MTI    = 4'd7;
  localparam logic [3:0] IRQ_MEI    = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_UPDATE   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  function automatic logic [XLEN-1:0] cause_ext(input logic irq, input logic [3:0] code);
    return {irq, {(XLEN-5){1'b0}}, code};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_trap_ctrl_if.sv
// ============================================================================
// Module   : ysyx_trap_ctrl_if
// Purpose  : Commit, CSR-file, flush and redirect signals of the trap sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ysyx_trap_ctrl_if;
  import ysyx_trap_ctrl_pkg::*;

  logic            cmt_valid;
  logic            cmt_ready;
  logic [XLEN-1:0] cmt_pc;
  logic [XLEN-1:0] cmt_tval;
  logic [XLEN-1:0] cmt_cause;
  logic            cmt_exc;
  logic            cmt_ecall;
  logic            cmt_ebreak;
  logic            cmt_mret;
  logic            cmt_kill;
  logic [1:0]      priv_mode;
  logic            mstatus_mie;
  logic [XLEN-1:0] mie;
  logic [XLEN-1:0] mip;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic            csr_trap;
  logic            csr_mret;
  logic [XLEN-1:0] csr_cause;
  logic [XLEN-1:0] csr_tval;
  logic [XLEN-1:0] csr_pc;
  logic            flush_req;
  logic            flush_ack;
  logic            redir_valid;
  logic            redir_ready;
  logic [XLEN-1:0] redir_pc;

  modport slave (
    input  cmt_valid, cmt_pc, cmt_tval, cmt_cause, cmt_exc, cmt_ecall, cmt_ebreak, cmt_mret,
    input  priv_mode, mstatus_mie, mie, mip, mtvec, mepc, flush_ack, redir_ready,
    output cmt_ready, cmt_kill, csr_trap, csr_mret, csr_cause, csr_tval, csr_pc,
    output flush_req, redir_valid, redir_pc
  );

  modport master (
    output cmt_valid, cmt_pc, cmt_tval, cmt_cause, cmt_exc, cmt_ecall, cmt_ebreak, cmt_mret,
    output priv_mode, mstatus_mie, mie, mip, mtvec, mepc, flush_ack, redir_ready,
    input  cmt_ready, cmt_kill, csr_trap, csr_mret, csr_cause, csr_tval, csr_pc,
    input  flush_req, redir_valid, redir_pc
  );

endinterface

`default_nettype wire

// File: rtl/ysyx_irq_prio.sv
// ============================================================================
// Module   : ysyx_irq_prio
// Purpose  : Fixed-priority encoder for machine interrupts (MEI > MSI > MTI).
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_irq_prio
  import ysyx_trap_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] i_pending,
  output logic            o_valid,
  output logic [3:0]      o_code
);

  logic w_unused;
  assign w_unused = ^i_pending;

  always_comb begin
    o_valid = 1'b1;
    o_code  = IRQ_MEI;
    if (i_pending[IRQ_MEI]) begin
      o_code = IRQ_MEI;
    end else if (i_pending[IRQ_MSI]) begin
      o_code = IRQ_MSI;
    end else if (i_pending[IRQ_MTI]) begin
      o_code = IRQ_MTI;
    end else begin
      o_valid = 1'b0;
      o_code  = 4'd0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_trap_ctrl.sv
// ============================================================================
// Module   : ysyx_trap_ctrl
// Purpose  : Commit-stage trap sequencer: accept event, drain, CSR update, redirect.
//            YSYX_TRAP_VECTORED_EN enables vectored interrupt targets.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_trap_ctrl
  import ysyx_trap_ctrl_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  ysyx_trap_ctrl_if.slave bus
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_tval;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_tgt;
  logic            r_is_mret;
  logic            r_is_irq;

  logic            w_irq_valid;
  logic [3:0]      w_irq_code;
  logic            w_irq_take;
  logic            w_accept;
  logic [XLEN-1:0] w_cause;
  logic [XLEN-1:0] w_tval;
  logic            w_is_mret;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_tgt;

  logic w_cmt_ready, w_cmt_kill, w_flush_req, w_csr_trap, w_csr_mret, w_redir_valid;

  ysyx_irq_prio u_prio (
    .i_pending (bus.mie & bus.mip),
    .o_valid   (w_irq_valid),
    .o_code    (w_irq_code)
  );

  assign w_irq_take = (bus.mstatus_mie || (bus.priv_mode != PRIV_M)) && w_irq_valid;
  assign w_accept   = (r_state == ST_IDLE) && bus.cmt_valid &&
                      (w_irq_take || bus.cmt_exc || bus.cmt_ecall || bus.cmt_ebreak || bus.cmt_mret);

  always_comb begin
    w_cause   = '0;
    w_tval    = '0;
    w_is_mret = 1'b0;
    if (w_irq_take) begin
      w_cause = cause_ext(1'b1, w_irq_code);
    end else if (bus.cmt_exc) begin
      w_cause = bus.cmt_cause;
      w_tval  = bus.cmt_tval;
    end else if (bus.cmt_ecall) begin
      case (bus.priv_mode)
        PRIV_M:  w_cause = cause_ext(1'b0, ECALL_M);
        PRIV_S:  w_cause = cause_ext(1'b0, ECALL_S);
        default: w_cause = cause_ext(1'b0, ECALL_U);
      endcase
    end else if (bus.cmt_ebreak) begin
      w_cause = cause_ext(1'b0, BREAKPOINT);
      w_tval  = bus.cmt_pc;
    end else begin
      w_is_mret = 1'b1;
    end
  end

  assign w_base = {bus.mtvec[XLEN-1:2], 2'b00};

  // Target is resolved against the CSR values live in UPDATE, not at acceptance.
  always_comb begin
    w_tgt = r_is_mret ? bus.mepc : w_base;
`ifdef YSYX_TRAP_VECTORED_EN
    if (r_is_irq && (bus.mtvec[1:0] == 2'b01)) begin
      w_tgt = w_base + {r_cause[XLEN-3:0], 2'b00};
    end
`endif
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cmt_ready   = 1'b0;
    w_cmt_kill    = 1'b0;
    w_flush_req   = 1'b0;
    w_csr_trap    = 1'b0;
    w_csr_mret    = 1'b0;
    w_redir_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cmt_ready = 1'b1;
        if (w_accept) begin
          w_cmt_kill  = w_irq_take;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_flush_req = 1'b1;
        if (bus.flush_ack) w_state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        w_csr_trap  = !r_is_mret;
        w_csr_mret  = r_is_mret;
        w_state_nxt = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        w_redir_valid = 1'b1;
        if (bus.redir_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cause   <= '0;
      r_tval    <= '0;
      r_pc      <= '0;
      r_tgt     <= '0;
      r_is_mret <= 1'b0;
      r_is_irq  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cause   <= w_cause;
        r_tval    <= w_tval;
        r_pc      <= bus.cmt_pc;
        r_is_mret <= w_is_mret;
        r_is_irq  <= w_irq_take;
      end
      if (r_state == ST_UPDATE) r_tgt <= w_tgt;
    end
  end

  assign bus.cmt_ready   = w_cmt_ready;
  assign bus.cmt_kill    = w_cmt_kill;
  assign bus.flush_req   = w_flush_req;
  assign bus.csr_trap    = w_csr_trap;
  assign bus.csr_mret    = w_csr_mret;
  assign bus.csr_cause   = r_cause;
  assign bus.csr_tval    = r_tval;
  assign bus.csr_pc      = r_pc;
  assign bus.redir_valid = w_redir_valid;
  assign bus.redir_pc    = r_tgt;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_trap_ctrl.sv
// ============================================================================
// Module   : tb_ysyx_trap_ctrl
// Purpose  : Self-checking bench: directed vector table, random events vs model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_trap_ctrl;
  import ysyx_trap_ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ysyx_trap_ctrl_if bus();
  ysyx_trap_ctrl dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic exc, ecall, ebreak, mret, mie_g;
    logic [1:0] priv;
    logic [31:0] pc, tval, cause, mie, mip, mtvec, mepc;
    int ack_dly, rdy_dly;
  } stim_t;
  typedef struct {
    logic kill, mret;
    logic [31:0] cause, tval, pc, tgt;
  } exp_t;
  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic [31:0] pend;
    logic take;
    int code;
    pend   = s.mie & s.mip & 32'h888;
    take   = (s.mie_g || s.priv != 2'd3) && (pend != 0);
    code   = pend[11] ? 11 : (pend[3] ? 3 : 7);
    e.kill = take;
    e.mret = 1'b0;
    e.cause = 32'h0;
    e.tval = 32'h0;
    e.pc   = s.pc;
    e.tgt  = s.mtvec & ~32'h3;
    if (take) begin
      e.cause = 32'h8000_0000 + 32'(code);
`ifdef YSYX_TRAP_VECTORED_EN
      if (s.mtvec[1:0] == 2'b01) e.tgt = e.tgt + 32'(4 * code);
`endif
    end else if (s.exc) begin
      e.cause = s.cause;
      e.tval  = s.tval;
    end else if (s.ecall) begin
      e.cause = (s.priv == 2'd3) ? 32'd11 : ((s.priv == 2'd1) ? 32'd9 : 32'd8);
    end else if (s.ebreak) begin
      e.cause = 32'd3;
      e.tval  = s.pc;
    end else begin
      e.mret = 1'b1;
      e.tgt  = s.mepc;
    end
    return e;
  endfunction

  task automatic clear_flags();
    bus.cmt_valid = 0; bus.cmt_exc = 0; bus.cmt_ecall = 0; bus.cmt_ebreak = 0; bus.cmt_mret = 0;
  endtask

  task automatic run_seq(input string tag, input stim_t s, input exp_t e);
    @(posedge clock); #1;
    bus.cmt_valid = 1; bus.cmt_exc = s.exc; bus.cmt_ecall = s.ecall;
    bus.cmt_ebreak = s.ebreak; bus.cmt_mret = s.mret; bus.mstatus_mie = s.mie_g;
    bus.priv_mode = s.priv; bus.cmt_pc = s.pc; bus.cmt_tval = s.tval; bus.cmt_cause = s.cause;
    bus.mie = s.mie; bus.mip = s.mip; bus.mtvec = s.mtvec; bus.mepc = s.mepc;
    bus.flush_ack = 0; bus.redir_ready = 0;
    @(negedge clock);
    chk({tag, " accept_ready"}, 32'(bus.cmt_ready), 32'd1);
    chk({tag, " kill"}, 32'(bus.cmt_kill), 32'(e.kill));
    @(posedge clock); #1;
    clear_flags();
    for (int k = 0; k < s.ack_dly; k++) begin
      @(negedge clock);
      chk({tag, " drain_flush"}, 32'(bus.flush_req), 32'd1);
      chk({tag, " drain_ready"}, 32'(bus.cmt_ready), 32'd0);
      @(posedge clock); #1;
    end
    bus.flush_ack = 1;
    @(negedge clock);
    chk({tag, " ack_flush"}, 32'(bus.flush_req), 32'd1);
    chk({tag, " early_strobe"}, 32'(bus.csr_trap | bus.csr_mret), 32'd0);
    @(posedge clock); #1;
    bus.flush_ack = 0;
    @(negedge clock);
    chk({tag, " csr_trap"}, 32'(bus.csr_trap), 32'(!e.mret));
    chk({tag, " csr_mret"}, 32'(bus.csr_mret), 32'(e.mret));
    chk({tag, " flush_low"}, 32'(bus.flush_req), 32'd0);
    if (!e.mret) begin
      chk({tag, " cause"}, bus.csr_cause, e.cause);
      chk({tag, " tval"}, bus.csr_tval, e.tval);
      chk({tag, " pc"}, bus.csr_pc, e.pc);
    end
    @(posedge clock); #1;
    for (int k = 0; k < s.rdy_dly; k++) begin
      @(negedge clock);
      chk({tag, " hold_valid"}, 32'(bus.redir_valid), 32'd1);
      chk({tag, " hold_pc"}, bus.redir_pc, e.tgt);
      chk({tag, " hold_ready"}, 32'(bus.cmt_ready), 32'd0);
      @(posedge clock); #1;
    end
    bus.redir_ready = 1;
    @(negedge clock);
    chk({tag, " redir_valid"}, 32'(bus.redir_valid), 32'd1);
    chk({tag, " redir_pc"}, bus.redir_pc, e.tgt);
    chk({tag, " strobe_once"}, 32'(bus.csr_trap | bus.csr_mret), 32'd0);
    @(posedge clock); #1;
    bus.redir_ready = 0;
    @(negedge clock);
    chk({tag, " back_idle"}, 32'(bus.cmt_ready), 32'd1);
    chk({tag, " redir_off"}, 32'(bus.redir_valid), 32'd0);
  endtask

  initial begin
    stim_t s;
    exp_t  e;
    int p;

    // exc ecall ebreak mret mie_g priv pc tval cause mie mip mtvec mepc ack rdy
    tbl[0] = '{'{0,1,0,0,0,2'd3,32'h80000100,32'h0,32'h0,32'h0,32'h0,32'h80001000,32'h0,0,0},
               '{0,0,32'hb,32'h0,32'h80000100,32'h80001000}};
    tbl[1] = '{'{0,0,1,0,0,2'd0,32'h80000200,32'h55,32'h0,32'h0,32'h0,32'h80001000,32'h0,1,0},
               '{0,0,32'h3,32'h80000200,32'h80000200,32'h80001000}};
    tbl[2] = '{'{0,0,0,1,0,2'd3,32'h80000210,32'h0,32'h0,32'h0,32'h0,32'h80001000,32'h80000204,0,5},
               '{0,1,32'h0,32'h0,32'h80000210,32'h80000204}};
    tbl[3] = '{'{1,0,0,0,1,2'd3,32'h80000300,32'hdead,32'h2,32'h888,32'h888,32'h80001000,32'h0,0,0},
               '{1,0,32'h8000000b,32'h0,32'h80000300,32'h80001000}};
`ifdef YSYX_TRAP_VECTORED_EN
    tbl[4] = '{'{0,0,0,0,1,2'd3,32'h80000400,32'h0,32'h0,32'h80,32'h80,32'h80001001,32'h0,2,1},
               '{1,0,32'h80000007,32'h0,32'h80000400,32'h8000101c}};
    tbl[8] = '{'{0,0,0,1,0,2'd0,32'h80000800,32'h0,32'h0,32'h8,32'h8,32'h80002001,32'h0,0,0},
               '{1,0,32'h80000003,32'h0,32'h80000800,32'h8000200c}};
`else
    tbl[4] = '{'{0,0,0,0,1,2'd3,32'h80000400,32'h0,32'h0,32'h80,32'h80,32'h80001001,32'h0,2,1},
               '{1,0,32'h80000007,32'h0,32'h80000400,32'h80001000}};
    tbl[8] = '{'{0,0,0,1,0,2'd0,32'h80000800,32'h0,32'h0,32'h8,32'h8,32'h80002001,32'h0,0,0},
               '{1,0,32'h80000003,32'h0,32'h80000800,32'h80002000}};
`endif
    tbl[5] = '{'{1,1,0,0,0,2'd1,32'h80000500,32'h1234,32'h5,32'h888,32'h0,32'h80003001,32'h0,0,0},
               '{0,0,32'h5,32'h1234,32'h80000500,32'h80003000}};
    tbl[6] = '{'{0,1,0,1,0,2'd1,32'h80000600,32'h0,32'h0,32'h0,32'h0,32'h80001000,32'h0,0,0},
               '{0,0,32'h9,32'h0,32'h80000600,32'h80001000}};
    tbl[7] = '{'{0,1,1,0,0,2'd0,32'h80000700,32'h0,32'h0,32'h0,32'h0,32'h80001000,32'h0,0,0},
               '{0,0,32'h8,32'h0,32'h80000700,32'h80001000}};
    tbl[9] = '{'{0,0,1,0,0,2'd3,32'h80000900,32'h0,32'h0,32'h888,32'h888,32'h80001000,32'h0,0,0},
               '{0,0,32'h3,32'h80000900,32'h80000900,32'h80001000}};

    clear_flags();
    bus.cmt_pc = 0; bus.cmt_tval = 0; bus.cmt_cause = 0; bus.priv_mode = 2'd3;
    bus.mstatus_mie = 0; bus.mie = 0; bus.mip = 0; bus.mtvec = 0; bus.mepc = 0;
    bus.flush_ack = 0; bus.redir_ready = 0;

    @(negedge clock);
    chk("rst cmt_ready", 32'(bus.cmt_ready), 32'd1);
    chk("rst outputs", 32'({bus.cmt_kill, bus.csr_trap, bus.csr_mret, bus.flush_req, bus.redir_valid}), 32'd0);
    chk("rst payload", bus.csr_cause | bus.csr_tval | bus.csr_pc | bus.redir_pc, 32'd0);
    @(posedge clock); #1;
    reset = 0;

    for (int i = 0; i < 10; i++) run_seq($sformatf("vec%0d", i), tbl[i].s, tbl[i].e);

    // Plain commit, masked interrupt and stray handshakes must not start a sequence.
    @(posedge clock); #1;
    bus.cmt_valid = 1; bus.priv_mode = 2'd3; bus.mstatus_mie = 0;
    bus.mie = 32'h888; bus.mip = 32'h888; bus.flush_ack = 1; bus.redir_ready = 1;
    @(negedge clock);
    chk("plain kill", 32'(bus.cmt_kill), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("plain stays idle", 32'({bus.cmt_ready, bus.flush_req, bus.csr_trap, bus.redir_valid}), 32'h8);
    @(posedge clock); #1;
    clear_flags(); bus.flush_ack = 0; bus.redir_ready = 0; bus.mie = 0; bus.mip = 0;

    // Reset asserted while draining.
    @(posedge clock); #1;
    bus.cmt_valid = 1; bus.cmt_ecall = 1;
    @(posedge clock); #1;
    clear_flags();
    @(negedge clock);
    chk("rstdrain flush", 32'(bus.flush_req), 32'd1);
    #2 reset = 1;
    #1;
    chk("rstdrain async", 32'({bus.cmt_ready, bus.flush_req, bus.csr_trap, bus.redir_valid}), 32'h8);
    chk("rstdrain payload", bus.csr_cause, 32'd0);
    @(posedge clock); #1;
    reset = 0; bus.flush_ack = 1; bus.redir_ready = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("postrst quiet", 32'({bus.csr_trap, bus.csr_mret, bus.redir_valid, bus.flush_req}), 32'd0);
    end
    bus.flush_ack = 0; bus.redir_ready = 0;

    for (int i = 0; i < 40; i++) begin
      s.exc = ($urandom_range(0, 3) == 0); s.ecall = ($urandom_range(0, 3) == 0);
      s.ebreak = ($urandom_range(0, 3) == 0); s.mret = ($urandom_range(0, 3) == 0);
      s.mie_g = 1'($urandom_range(0, 1));
      p = $urandom_range(0, 2);
      s.priv = (p == 2) ? 2'd3 : 2'(p);
      s.pc = $urandom & ~32'h3; s.tval = $urandom; s.cause = $urandom_range(0, 15);
      s.mie = $urandom; s.mip = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
      s.mtvec = ($urandom & ~32'h3) | 32'($urandom_range(0, 1));
      s.mepc = $urandom & ~32'h3;
      s.ack_dly = $urandom_range(0, 2); s.rdy_dly = $urandom_range(0, 2);
      e = model(s);
      if (!e.kill && !s.exc && !s.ecall && !s.ebreak && !s.mret) begin
        s.ecall = 1;
        e = model(s);
      end
      run_seq($sformatf("rnd%0d", i), s, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ysyx_trap_ctrl.md
# ysyx_trap_ctrl

Trap sequencer for the machine-mode CSR file. It sits at the commit stage between the ROB/commit port, the CSR file's trap/mret inputs and the frontend redirect path. It arbitrates synchronous exceptions, ecall/ebreak/mret and enabled machine interrupts, then drains the pipeline. It issues exactly one CSR trap/mret update and redirects fetch to the handler or to mepc.

## Interface
- XLEN, `YSYX_XLEN, data width.
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; returns the FSM to IDLE immediately.
- cmt_valid / cmt_ready  in / out  1 / 1  commit handshake; an instruction retires on cmt_valid && cmt_ready.
- cmt_pc, cmt_tval, cmt_cause  in  XLEN each  PC, trap value and cause of the committing instruction.
- cmt_exc, cmt_ecall, cmt_ebreak, cmt_mret  in  1 each  event flags of the committing instruction.
- cmt_kill  out  1  1-cycle pulse: the committing instruction is squashed by an interrupt and not retired.
- priv_mode  in  2  current privilege (M=3, S=1, U=0).
- mstatus_mie  in  1  global M interrupt enable.
- mie, mip  in  XLEN each  interrupt enable and pending.
- mtvec, mepc  in  XLEN each  live CSR values.
- csr_trap, csr_mret  out  1 each  1-cycle update strobes to the CSR file.
- csr_cause, csr_tval, csr_pc  out  XLEN each  trap payload, stable while csr_trap is high.
- flush_req / flush_ack  out / in  1 / 1  pipeline drain handshake.
- redir_valid / redir_ready  out / in  1 / 1  fetch redirect handshake.
- redir_pc  out  XLEN  redirect target.

## Operation
- FSM states: IDLE, DRAIN, UPDATE, REDIRECT.
- IDLE:
  - cmt_ready=1.
  - An event is accepted when cmt_valid and any of the following holds: an interrupt is takeable, cmt_exc, cmt_ecall, cmt_ebreak or cmt_mret.
  - On acceptance, latch the payload and go to DRAIN.
  - A plain commit with no event stays in IDLE.
- Interrupts:
  - takeable = (mstatus_mie || priv_mode!=M) && |(mie & mip & 'h888).
  - Interrupt priority: MEI(11) > MSI(3) > MTI(7).
  - cause = {1'b1, code}; tval=0; pc=cmt_pc; cmt_kill pulses.
- Event priority when several are present on the same instruction: interrupt > cmt_exc > ecall > ebreak > mret.
- Synchronous event payloads:
  - exc: cause=cmt_cause, tval=cmt_tval.
  - ecall: cause = 11 (M), 9 (S) or 8 (U); tval=0.
  - ebreak: cause=3, tval=cmt_pc.
  - All use pc=cmt_pc.
- DRAIN: flush_req=1 and cmt_ready=0; advance to UPDATE in the cycle after flush_ack is seen.
- UPDATE: exactly one cycle.
  - Pulse csr_trap for trap events, or csr_mret for mret.
  - Latch the target: trap target = {mtvec[XLEN-1:2],2'b00}; mret target = mepc as sampled in this cycle.
- REDIRECT: hold redir_valid and a stable redir_pc until redir_ready; in the handshake cycle return to IDLE.
- Reset values: every output is 0 except cmt_ready=1; FSM is IDLE; latched payload is 0.

## Timing
- Acceptance at cycle N, flush_ack at cycle M ≥ N+1:
  - flush_req is high from N+1 through M.
  - csr_trap/csr_mret is high at M+1.
  - redir_valid rises at M+2.
  - If redir_ready is already high, IDLE is reached at M+3.
  - Minimum event-to-IDLE is 4 cycles.
- flush_ack is ignored outside DRAIN.
- redir_ready is ignored outside REDIRECT.
- Interrupts arriving outside IDLE stay pending in mip and are evaluated again in IDLE.
- cmt_ready is low in every state except IDLE; no second event can be accepted until the current sequence finishes.
- Reset asserted mid-sequence clears the FSM to IDLE asynchronously. No csr strobe may occur in the cycle after reset deasserts.

## Configuration
- YSYX_TRAP_VECTORED_EN:
  - Defined: interrupts with mtvec[1:0]==1 redirect to base + 4*code. Exceptions, ecall and ebreak always redirect to base.
  - Undefined: all traps redirect to base and mtvec[1:0] is ignored.

## Structure
- Shared package `ysyx.svh` holds:
  - the state enum;
  - cause constants (ECALL_M/S/U, BREAKPOINT, MEI/MSI/MTI codes);
  - the existing PRIV_* defines.
- Sub-module ysyx_irq_prio: combinational priority encoder from mie&mip to {valid, code[3:0]}.

## Test plan
- ecall, priv=M, pc=0x80000100, flush_ack one cycle later:
  - csr_trap with cause=0xb, csr_pc=0x80000100, tval=0;
  - redir_pc = mtvec base (mtvec=0x80001000).
- ebreak, priv=U: cause=3, tval=pc.
- mret, mepc=0x80000204:
  - csr_mret pulses once;
  - redir_pc=0x80000204;
  - csr_trap stays 0.
- mip=mie=0x888 with mstatus_mie=1 and cmt_exc set on the same instruction:
  - cmt_kill pulses;
  - cause=0x8000000b (MEI wins over MSI/MTI and over the exception).
- Vectored mode, mtvec=0x80001001 with MTI pending:
  - redir_pc=0x8000101c with the macro defined;
  - redir_pc=0x80001000 without it.
- Reset asserted while in DRAIN:
  - outputs immediately return to reset values;
  - after release, no csr strobe and no redirect occurs.
- Hold redir_ready=0 for 5 cycles: redir_valid stays high with stable redir_pc; cmt_ready stays 0.
